// File: rtl/if_stage_pkg.sv
// Shared widths and the instruction-buffer entry type for the fetch stage.
package if_stage_pkg;

  localparam int INST_WIDTH     = 32;
  localparam int INST_FETCH_NUM = 4;
  localparam int INST_PACK      = INST_WIDTH * INST_FETCH_NUM;

  typedef struct packed {
    logic                  valid;
    logic [INST_WIDTH-1:0] pc;
    logic [INST_WIDTH-1:0] inst;
  } ib_entry_t;

endpackage

// File: rtl/if_pc_gen.sv
// Fetch PC register and next-PC selection: redirect, then predicted PC on an
// accepted fetch, otherwise hold.
module if_pc_gen
  import if_stage_pkg::*;
#(
  parameter int PC_WIDTH = INST_WIDTH
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                stall,
  input  logic                take_branch,
  input  logic [PC_WIDTH-1:0] branch_pc,
  input  logic [PC_WIDTH-1:0] pc_predicted,
  input  logic                data_valid,
  output logic [PC_WIDTH-1:0] pc,
  output logic                accepted
);

  logic [PC_WIDTH-1:0] pc_next;

  assign accepted = data_valid & ~stall & ~take_branch;

  // Next-PC priority mux.
  always_comb begin
    pc_next = pc;
    if (take_branch) begin
      pc_next = branch_pc;
    end else if (accepted) begin
      pc_next = pc_predicted;
    end else begin
      pc_next = pc;
    end
  end

  // PC register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc <= '0;
    end else begin
      pc <= pc_next;
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: issues the aligned fetch address and registers each
// accepted I-cache group into per-slot instruction-buffer entries.
module if_stage #(
  parameter int INST_WIDTH     = if_stage_pkg::INST_WIDTH,
  parameter int INST_FETCH_NUM = if_stage_pkg::INST_FETCH_NUM,
  parameter int INST_PACK      = INST_WIDTH * INST_FETCH_NUM
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      stall,
  input  logic [INST_WIDTH-1:0]     pc_predicted,
  input  logic                      take_branch,
  input  logic [INST_WIDTH-1:0]     branch_pc,
  input  logic [INST_PACK-1:0]      Icache2proc_data,
  input  logic                      Icache2proc_data_valid,
  output logic [INST_WIDTH-1:0]     proc2Icache_addr,
  output if_stage_pkg::ib_entry_t   insts_out [INST_FETCH_NUM],
  output logic                      valid
);

  localparam int BYTE_BITS   = $clog2(INST_WIDTH / 8);
  localparam int SLOT_BITS   = $clog2(INST_FETCH_NUM);
  localparam int OFFSET_BITS = $clog2(INST_PACK / 8);

  logic [INST_WIDTH-1:0]   pc;
  logic                    accepted;
  if_stage_pkg::ib_entry_t group [INST_FETCH_NUM];

  if_pc_gen #(
    .PC_WIDTH (INST_WIDTH)
  ) u_pc_gen (
    .clock        (clock),
    .reset        (reset),
    .stall        (stall),
    .take_branch  (take_branch),
    .branch_pc    (branch_pc),
    .pc_predicted (pc_predicted),
    .data_valid   (Icache2proc_data_valid),
    .pc           (pc),
    .accepted     (accepted)
  );

  assign proc2Icache_addr = {pc[INST_WIDTH-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};

  // Slots below the PC's own slot were fetched only because of line alignment.
  always_comb begin
    for (int i = 0; i < INST_FETCH_NUM; i++) begin
      group[i].inst  = Icache2proc_data[INST_WIDTH*i +: INST_WIDTH];
      group[i].pc    = {pc[INST_WIDTH-1:OFFSET_BITS], SLOT_BITS'(i), {BYTE_BITS{1'b0}}};
      group[i].valid = (SLOT_BITS'(i) >= pc[OFFSET_BITS-1:BYTE_BITS]);
    end
  end

  // Output register: flush on redirect, hold on stall, load on accepted fetch.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid <= 1'b0;
      for (int i = 0; i < INST_FETCH_NUM; i++) begin
        insts_out[i] <= '0;
      end
    end else if (take_branch) begin
      valid <= 1'b0;
    end else if (stall) begin
      valid <= valid;
    end else if (accepted) begin
      valid     <= 1'b1;
      insts_out <= group;
    end else begin
      valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: expected groups queued when a fetch is driven,
// popped and compared when the registered output appears.
module tb_if_stage;
  import if_stage_pkg::*;

  localparam int EW = $bits(ib_entry_t);

  logic            clock = 1'b0;
  logic            reset;
  logic            stall;
  logic [31:0]     pc_predicted;
  logic            take_branch;
  logic [31:0]     branch_pc;
  logic [127:0]    data;
  logic            dv;
  logic [31:0]     proc2Icache_addr;
  ib_entry_t       insts_out [4];
  logic            valid;

  int              errors = 0;
  int              checks = 0;
  logic [31:0]     model_pc;
  logic [4*EW-1:0] sb_q [$];
  logic [4*EW-1:0] last_grp;

  if_stage dut (
    .clock                  (clock),
    .reset                  (reset),
    .stall                  (stall),
    .pc_predicted           (pc_predicted),
    .take_branch            (take_branch),
    .branch_pc              (branch_pc),
    .Icache2proc_data       (data),
    .Icache2proc_data_valid (dv),
    .proc2Icache_addr       (proc2Icache_addr),
    .insts_out              (insts_out),
    .valid                  (valid)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [4*EW-1:0] exp_group(input logic [31:0] pc, input logic [127:0] d);
    logic [4*EW-1:0] g;
    ib_entry_t       e;
    logic [1:0]      s;
    g = '0;
    for (int i = 0; i < 4; i++) begin
      s       = i[1:0];
      e.valid = (s >= pc[3:2]);
      e.pc    = {pc[31:4], s, 2'b00};
      e.inst  = d[32*i +: 32];
      g[EW*i +: EW] = e;
    end
    return g;
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic fetch(input logic [31:0] pred, input logic [127:0] d);
    dv           = 1'b1;
    stall        = 1'b0;
    take_branch  = 1'b0;
    data         = d;
    pc_predicted = pred;
    sb_q.push_back(exp_group(model_pc, d));
    model_pc     = pred;
  endtask

  task automatic check_state(input string tag, input logic exp_valid, input logic [31:0] exp_addr);
    check({tag, " valid"}, {95'b0, valid}, {95'b0, exp_valid});
    check({tag, " addr"}, {64'b0, proc2Icache_addr}, {64'b0, exp_addr});
  endtask

  task automatic check_group(input string tag);
    logic [4*EW-1:0] g;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s: observed=output group expected=queued group (queue empty)", tag);
    end else begin
      g        = sb_q.pop_front();
      last_grp = g;
      for (int i = 0; i < 4; i++) begin
        check($sformatf("%s slot%0d", tag, i), {{(96-EW){1'b0}}, insts_out[i]},
              {{(96-EW){1'b0}}, g[EW*i +: EW]});
      end
    end
  endtask

  task automatic check_zero(input string tag);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("%s slot%0d zero", tag, i), {{(96-EW){1'b0}}, insts_out[i]}, 96'b0);
    end
  endtask

  initial begin
    reset        = 1'b0;
    stall        = 1'b0;
    take_branch  = 1'b0;
    branch_pc    = 32'h0;
    pc_predicted = 32'h0;
    data         = 128'h0;
    dv           = 1'b0;
    model_pc     = 32'h0;
    last_grp     = '0;

    #3;
    check_state("reset_async", 1'b0, 32'h0);
    check_zero("reset_async");
    step();
    step();
    check_state("in_reset", 1'b0, 32'h0);

    reset = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      check_state($sformatf("cache_invalid%0d", c), 1'b0, 32'h0);
    end

    fetch(32'h10, {32'h44, 32'h33, 32'h22, 32'h11});
    step();
    check_state("grp0", 1'b1, 32'h10);
    check_group("grp0");

    stall        = 1'b1;
    dv           = 1'b1;
    data         = {32'hDEAD_0003, 32'hDEAD_0002, 32'hDEAD_0001, 32'hDEAD_0000};
    pc_predicted = 32'h20;
    for (int c = 0; c < 3; c++) begin
      step();
      check_state($sformatf("stall%0d", c), 1'b1, 32'h10);
      for (int i = 0; i < 4; i++) begin
        check($sformatf("stall%0d hold slot%0d", c, i), {{(96-EW){1'b0}}, insts_out[i]},
              {{(96-EW){1'b0}}, last_grp[EW*i +: EW]});
      end
    end

    fetch(32'h30, {32'hA3, 32'hA2, 32'hA1, 32'hA0});
    step();
    check_state("resume", 1'b1, 32'h30);
    check_group("resume");

    take_branch = 1'b1;
    branch_pc   = 32'h108;
    dv          = 1'b1;
    step();
    check_state("flush", 1'b0, 32'h100);
    model_pc = 32'h108;

    fetch(32'h120, {32'hB3, 32'hB2, 32'hB1, 32'hB0});
    step();
    check_state("branch_tgt", 1'b1, 32'h120);
    check("branch_tgt slot0 ev", {95'b0, insts_out[0].valid}, 96'h0);
    check("branch_tgt slot2 pc", {64'b0, insts_out[2].pc}, {64'b0, 32'h108});
    check_group("branch_tgt");

    dv = 1'b0;
    step();
    check_state("no_data", 1'b0, 32'h120);

    fetch(32'h130, {32'hC3, 32'hC2, 32'hC1, 32'hC0});
    step();
    check_state("refetch", 1'b1, 32'h130);
    check_group("refetch");

    stall       = 1'b1;
    take_branch = 1'b1;
    branch_pc   = 32'h200;
    step();
    check_state("stall_branch", 1'b0, 32'h200);
    stall       = 1'b0;
    take_branch = 1'b0;
    model_pc    = 32'h200;

    fetch(32'hFFFF_FFF4, {32'hD3, 32'hD2, 32'hD1, 32'hD0});
    step();
    check_state("pre_wrap", 1'b1, 32'hFFFF_FFF0);
    check_group("pre_wrap");

    fetch(32'h8, {32'hE3, 32'hE2, 32'hE1, 32'hE0});
    step();
    check_state("wrap", 1'b1, 32'h0);
    check_group("wrap");

    dv = 1'b0;
    #3;
    reset = 1'b0;
    #1;
    check_state("async_rst", 1'b0, 32'h0);
    check_zero("async_rst");

    step();
    reset    = 1'b1;
    model_pc = 32'h0;
    fetch(32'h40, {32'hF3, 32'hF2, 32'hF1, 32'hF0});
    step();
    check_state("post_rst", 1'b1, 32'h40);
    check_group("post_rst");

    check("sb_empty", 96'(sb_q.size()), 96'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
